// File: rtl/caixa_embalagem_if.sv
// Bottle/crate handshake bundle between the sealing stage and the crate loading station.
// master = upstream/stimulus side, slave = the loading station.
interface caixa_embalagem_if;
   logic       garrafa_lacrada;
   logic       caixa_presente;
   logic       aceita_garrafa;
   logic       motor_caixa;
   logic       atuador_fecha;
   logic       inc_duzia;
   logic [3:0] contagem_garrafas;
   logic [7:0] total_caixas;
   logic       garrafa_perdida;
   logic       alarme_caixa;
   logic [2:0] estado;

   modport master (
      output garrafa_lacrada, caixa_presente,
      input  aceita_garrafa, motor_caixa, atuador_fecha, inc_duzia,
             contagem_garrafas, total_caixas, garrafa_perdida, alarme_caixa, estado
   );

   modport slave (
      input  garrafa_lacrada, caixa_presente,
      output aceita_garrafa, motor_caixa, atuador_fecha, inc_duzia,
             contagem_garrafas, total_caixas, garrafa_perdida, alarme_caixa, estado
   );
endinterface

// File: rtl/caixa_embalagem.sv
// Crate loading station: fetches a crate, fills it with sealed bottles, closes it and dispatches it.
// Optional macro CAIXA_TIMEOUT_EN adds a dispatch-wait watchdog that raises alarme_caixa.
module caixa_embalagem #(
   parameter int GARRAFAS_POR_CAIXA = 12,
   parameter int FECHA_CICLOS       = 4,
   parameter int TIMEOUT_CICLOS     = 50
) (
   input logic               clk,
   input logic               reset,
   caixa_embalagem_if.slave  bus
);

   localparam int FW = (FECHA_CICLOS > 1) ? $clog2(FECHA_CICLOS) : 1;
   localparam logic [3:0]    CHEIA      = 4'(GARRAFAS_POR_CAIXA);
   localparam logic [FW-1:0] FECHA_ULT  = FW'(FECHA_CICLOS - 1);

   if (GARRAFAS_POR_CAIXA < 1 || GARRAFAS_POR_CAIXA > 15 || FECHA_CICLOS < 1 || TIMEOUT_CICLOS < 1)
   begin : g_param_invalid
      $error("caixa_embalagem: parameter out of range");
   end

   typedef enum logic [2:0] {
      S_BUSCA  = 3'b000,
      S_ENCHE  = 3'b001,
      S_FECHA  = 3'b010,
      S_EXPEDE = 3'b011
   } estado_t;

   estado_t       state, state_nx;
   logic [3:0]    contagem, contagem_nx;
   logic [7:0]    total, total_nx;
   logic          perdida, perdida_nx;
   logic          alarme, alarme_nx;
   logic [FW-1:0] fecha_cnt, fecha_cnt_nx;
   logic          aceita, motor, atuador, inc;

`ifdef CAIXA_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CICLOS + 1);
   localparam logic [TW-1:0] ESPERA_ULT = TW'(TIMEOUT_CICLOS - 1);
   logic [TW-1:0] espera, espera_nx;
`endif

   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= S_BUSCA;
         contagem  <= '0;
         total     <= '0;
         perdida   <= 1'b0;
         alarme    <= 1'b0;
         fecha_cnt <= '0;
`ifdef CAIXA_TIMEOUT_EN
         espera    <= '0;
`endif
      end else begin
         state     <= state_nx;
         contagem  <= contagem_nx;
         total     <= total_nx;
         perdida   <= perdida_nx;
         alarme    <= alarme_nx;
         fecha_cnt <= fecha_cnt_nx;
`ifdef CAIXA_TIMEOUT_EN
         espera    <= espera_nx;
`endif
      end
   end

   // Outputs are gated with reset so nothing is driven while the station is held in reset.
   always_comb begin
      state_nx     = state;
      contagem_nx  = contagem;
      total_nx     = total;
      perdida_nx   = perdida;
      alarme_nx    = alarme;
      fecha_cnt_nx = fecha_cnt;
      aceita       = 1'b0;
      motor        = 1'b0;
      atuador      = 1'b0;
      inc          = 1'b0;
`ifdef CAIXA_TIMEOUT_EN
      espera_nx    = '0;
`endif

      case (state)
         S_BUSCA: begin
            motor = reset;
            if (bus.caixa_presente) state_nx = S_ENCHE;
         end
         S_ENCHE: begin
            aceita = reset;
            if (!bus.caixa_presente) begin
               // Crate lost: a bottle taken this cycle leaves with the crate.
               state_nx    = S_BUSCA;
               contagem_nx = '0;
               alarme_nx   = 1'b1;
            end else if (bus.garrafa_lacrada) begin
               contagem_nx = contagem + 4'd1;
               if (contagem_nx == CHEIA) begin
                  state_nx     = S_FECHA;
                  fecha_cnt_nx = '0;
               end
            end
         end
         S_FECHA: begin
            atuador = reset;
            inc     = reset && (fecha_cnt == '0);
            if (fecha_cnt == FECHA_ULT) state_nx = S_EXPEDE;
            else                        fecha_cnt_nx = fecha_cnt + 1'b1;
         end
         S_EXPEDE: begin
            motor = reset;
            if (!bus.caixa_presente) begin
               state_nx    = S_BUSCA;
               total_nx    = total + 8'd1;
               contagem_nx = '0;
            end
`ifdef CAIXA_TIMEOUT_EN
            else if (espera == ESPERA_ULT) begin
               espera_nx = espera;
               alarme_nx = 1'b1;
            end else begin
               espera_nx = espera + 1'b1;
            end
`endif
         end
         default: state_nx = S_BUSCA;
      endcase

      if (bus.garrafa_lacrada && !aceita) perdida_nx = 1'b1;
   end

   assign bus.aceita_garrafa    = aceita;
   assign bus.motor_caixa       = motor;
   assign bus.atuador_fecha     = atuador;
   assign bus.inc_duzia         = inc;
   assign bus.contagem_garrafas = contagem;
   assign bus.total_caixas      = total;
   assign bus.garrafa_perdida   = perdida;
   assign bus.alarme_caixa      = alarme;
   assign bus.estado            = state;

endmodule

// File: tb/tb_caixa_embalagem.sv
// Self-checking bench for caixa_embalagem: directed scenarios plus randomized traffic
// compared every cycle against a behavioural crate/bottle model.
module tb_caixa_embalagem;
   localparam int N = 12;
   localparam int F = 4;
   localparam int T = 50;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   caixa_embalagem_if bus ();

   caixa_embalagem #(
      .GARRAFAS_POR_CAIXA(N),
      .FECHA_CICLOS(F),
      .TIMEOUT_CICLOS(T)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   int checks = 0;
   int failures = 0;

   // Model: phase 0 waiting for crate, 1 filling, 2 closing, 3 dispatching
   int m_phase, m_cnt, m_total, m_close, m_wait;
   bit m_perd, m_alarm;
   int n_inc, n_act;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic void model_step(input bit r, input bit g, input bit c);
      if (!r) begin
         m_phase = 0; m_cnt = 0; m_total = 0; m_perd = 0; m_alarm = 0;
         return;
      end
      if (g && m_phase != 1) m_perd = 1;
      case (m_phase)
         0: if (c) m_phase = 1;
         1: begin
            if (!c) begin
               m_phase = 0; m_cnt = 0; m_alarm = 1;
            end else if (g) begin
               m_cnt++;
               if (m_cnt == N) begin
                  m_phase = 2; m_close = F;
               end
            end
         end
         2: begin
            m_close--;
            if (m_close == 0) begin
               m_phase = 3; m_wait = 0;
            end
         end
         default: begin
            if (!c) begin
               m_phase = 0; m_total = (m_total + 1) % 256; m_cnt = 0;
            end else begin
               m_wait++;
`ifdef CAIXA_TIMEOUT_EN
               if (m_wait >= T) m_alarm = 1;
`endif
            end
         end
      endcase
   endfunction

   task automatic cycle(input bit r, input bit g, input bit c);
      reset = r;
      bus.garrafa_lacrada = g;
      bus.caixa_presente = c;
      #1;
      check("estado", 32'(bus.estado), 32'(m_phase));
      check("contagem", 32'(bus.contagem_garrafas), 32'(m_cnt));
      check("total", 32'(bus.total_caixas), 32'(m_total));
      check("perdida", 32'(bus.garrafa_perdida), 32'(m_perd));
      check("alarme", 32'(bus.alarme_caixa), 32'(m_alarm));
      check("aceita", 32'(bus.aceita_garrafa), 32'(r && m_phase == 1));
      check("motor", 32'(bus.motor_caixa), 32'(r && (m_phase == 0 || m_phase == 3)));
      check("atuador", 32'(bus.atuador_fecha), 32'(r && m_phase == 2));
      check("inc_duzia", 32'(bus.inc_duzia), 32'(r && m_phase == 2 && m_close == F));
      if (bus.inc_duzia === 1'b1) n_inc++;
      if (bus.atuador_fecha === 1'b1) n_act++;
      @(posedge clk);
      model_step(r, g, c);
      #1;
   endtask

   task automatic do_reset();
      cycle(1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b1, 1'b1);
      n_inc = 0;
      n_act = 0;
   endtask

   // Fill until full (or bound expires), close, then dispatch after a short wait.
   task automatic run_crate(input bit rnd);
      int guard;
      cycle(1'b1, 1'b0, 1'b1);
      guard = 0;
      while (m_phase == 1 && guard < 300) begin
         cycle(1'b1, rnd ? 1'($urandom_range(0, 1)) : 1'b1, 1'b1);
         guard++;
      end
      while (m_phase == 2 && guard < 300) begin
         cycle(1'b1, rnd ? 1'($urandom_range(0, 1)) : 1'b0, 1'b1);
         guard++;
      end
      if (guard >= 300) check("crate_timeout", 32'(guard), 32'd0);
      repeat ($urandom_range(0, 3)) cycle(1'b1, 1'b0, 1'b1);
      cycle(1'b1, 1'b0, 1'b0);
   endtask

   initial begin
      reset = 1'b0;
      bus.garrafa_lacrada = 1'b0;
      bus.caixa_presente = 1'b0;
      m_phase = 0; m_cnt = 0; m_total = 0; m_close = 0; m_wait = 0;
      m_perd = 0; m_alarm = 0; n_inc = 0; n_act = 0;
      repeat (2) @(posedge clk);
      #1;

      // Reset state
      do_reset();
      check("rst_estado", 32'(bus.estado), 32'd0);
      check("rst_total", 32'(bus.total_caixas), 32'd0);

      // Normal fill
      run_crate(1'b0);
      check("fill_inc", 32'(n_inc), 32'd1);
      check("fill_act", 32'(n_act), 32'(F));
      check("fill_total", 32'(bus.total_caixas), 32'd1);
      check("fill_cnt", 32'(bus.contagem_garrafas), 32'd0);
      check("fill_estado", 32'(bus.estado), 32'd0);

      // Bottle offered while closing is dropped
      do_reset();
      cycle(1'b1, 1'b0, 1'b1);
      repeat (N) cycle(1'b1, 1'b1, 1'b1);
      cycle(1'b1, 1'b1, 1'b1);
      check("drop_cnt", 32'(bus.contagem_garrafas), 32'(N));
      check("drop_perdida", 32'(bus.garrafa_perdida), 32'd1);

      // Crate lost at count 5
      do_reset();
      cycle(1'b1, 1'b0, 1'b1);
      repeat (5) cycle(1'b1, 1'b1, 1'b1);
      cycle(1'b1, 1'b1, 1'b0);
      check("lost_estado", 32'(bus.estado), 32'd0);
      check("lost_cnt", 32'(bus.contagem_garrafas), 32'd0);
      check("lost_alarme", 32'(bus.alarme_caixa), 32'd1);
      check("lost_inc", 32'(n_inc), 32'd0);

      // Reset during the second closing cycle
      do_reset();
      cycle(1'b1, 1'b0, 1'b1);
      repeat (N) cycle(1'b1, 1'b1, 1'b1);
      cycle(1'b1, 1'b0, 1'b1);
      cycle(1'b0, 1'b0, 1'b1);
      check("midrst_estado", 32'(bus.estado), 32'd0);
      check("midrst_atuador", 32'(bus.atuador_fecha), 32'd0);
      check("midrst_cnt", 32'(bus.contagem_garrafas), 32'd0);

      // Dispatch wait
      do_reset();
      cycle(1'b1, 1'b0, 1'b1);
      repeat (N) cycle(1'b1, 1'b1, 1'b1);
      repeat (F) cycle(1'b1, 1'b0, 1'b1);
      repeat (T) cycle(1'b1, 1'b0, 1'b1);
`ifdef CAIXA_TIMEOUT_EN
      check("wait_alarme", 32'(bus.alarme_caixa), 32'd1);
`else
      check("wait_alarme", 32'(bus.alarme_caixa), 32'd0);
`endif
      check("wait_estado", 32'(bus.estado), 32'd3);
      check("wait_motor", 32'(bus.motor_caixa), 32'd1);
      cycle(1'b1, 1'b0, 1'b0);

      // 256 crates wrap the dispatch counter
      do_reset();
      for (int k = 0; k < 256; k++) run_crate(1'b1);
      check("wrap_total", 32'(bus.total_caixas), 32'd0);
      check("wrap_inc", 32'(n_inc), 32'd256);

      // Free-running random traffic
      do_reset();
      for (int k = 0; k < 3000; k++)
         cycle(($urandom_range(0, 199) != 0), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 9) != 0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
